// File: rtl/cu33_pkg.sv
// Shared defaults and fetch FSM encoding for the IFM fetch slice.
package cu33_pkg;

  localparam int IFM_DW = 8;
  localparam int IFM_AW = 12;
  localparam int IFM_LW = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifm_fetch_if.sv
// Job control, SRAM read port and IFM column output of the fetch block.
interface ifm_fetch_if
  import cu33_pkg::*;
#(
  parameter int DW = IFM_DW,
  parameter int AW = IFM_AW,
  parameter int LW = IFM_LW
) ();

  logic                 start;
  logic [AW-1:0]        cfg_base;
  logic [LW-1:0]        cfg_w;
  logic [LW-1:0]        cfg_h;
  logic                 stall;
  logic                 sram_en;
  logic [AW-1:0]        sram_addr;
  logic signed [DW-1:0] sram_rdata;
  logic signed [DW-1:0] ifm_row0;
  logic signed [DW-1:0] ifm_row1;
  logic signed [DW-1:0] ifm_row2;
  logic                 ifm_read;
  logic                 win_valid;
  logic                 busy;
  logic                 done;

  // Fetch block side.
  modport master (
    input  start, cfg_base, cfg_w, cfg_h, stall, sram_rdata,
    output sram_en, sram_addr, ifm_row0, ifm_row1, ifm_row2,
           ifm_read, win_valid, busy, done
  );

  // Controller / SRAM / consumer side.
  modport slave (
    output start, cfg_base, cfg_w, cfg_h, stall, sram_rdata,
    input  sram_en, sram_addr, ifm_row0, ifm_row1, ifm_row2,
           ifm_read, win_valid, busy, done
  );

endinterface

// File: rtl/ifm_addr_gen.sv
// Walks the 3-row band column by column; addresses come from running
// pointers (row start, k*W offset) so no multiplier is needed.
module ifm_addr_gen
  import cu33_pkg::*;
#(
  parameter int AW = IFM_AW,
  parameter int LW = IFM_LW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          adv,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] w,
  input  logic [LW-1:0] h,
  output logic [AW-1:0] addr,
  output logic [1:0]    k,
  output logic [LW-1:0] col,
  output logic          last
);

  logic [AW-1:0] row_ptr_r;
  logic [AW-1:0] koff_r;
  logic [LW-1:0] row_r;
  logic [LW-1:0] col_r;
  logic [1:0]    k_r;
  logic [AW-1:0] w_ext_s;
  logic          col_end_s;

  assign w_ext_s   = AW'(w);
  assign col_end_s = (col_r == (w - LW'(1)));
  assign addr      = row_ptr_r + koff_r + AW'(col_r);
  assign k         = k_r;
  assign col       = col_r;
  assign last      = (row_r == (h - LW'(3))) && col_end_s && (k_r == 2'd2);

  // Counter and pointer update: k fastest, then column, then band row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_ptr_r <= '0;
      koff_r    <= '0;
      row_r     <= '0;
      col_r     <= '0;
      k_r       <= 2'd0;
    end else if (load) begin
      row_ptr_r <= base;
      koff_r    <= '0;
      row_r     <= '0;
      col_r     <= '0;
      k_r       <= 2'd0;
    end else if (adv) begin
      if (k_r == 2'd2) begin
        k_r    <= 2'd0;
        koff_r <= '0;
        if (col_end_s) begin
          col_r     <= '0;
          row_r     <= row_r + LW'(1);
          row_ptr_r <= row_ptr_r + w_ext_s;
        end else begin
          col_r <= col_r + LW'(1);
        end
      end else begin
        k_r    <= k_r + 2'd1;
        koff_r <= koff_r + w_ext_s;
      end
    end
  end

endmodule

// File: rtl/ifm_fetch.sv
// Fetches 3-row IFM columns from SRAM and presents them as one strobed
// column per three reads, flagging when a full 3x3 window is available.
module ifm_fetch
  import cu33_pkg::*;
#(
  parameter int DW = IFM_DW,
  parameter int AW = IFM_AW,
  parameter int LW = IFM_LW
) (
  input logic         clk,
  input logic         rstn,
  ifm_fetch_if.master bus
);

  function automatic logic dims_ok(input logic [LW-1:0] w, input logic [LW-1:0] h);
    return (w >= LW'(3)) && (h >= LW'(3));
  endfunction

  fetch_state_e         state_r;
  fetch_state_e         state_nxt_s;
  logic                 load_s;
  logic                 adv_s;
  logic                 sram_en_s;
  logic [LW-1:0]        cfg_w_r;
  logic [LW-1:0]        cfg_h_r;
  logic [AW-1:0]        addr_s;
  logic [1:0]           k_s;
  logic [LW-1:0]        col_s;
  logic                 last_s;
  logic                 rd_vld_r;
  logic [1:0]           rd_k_r;
  logic                 rd_win_r;
  logic                 k2_vld_s;
  logic signed [DW-1:0] stage0_r;
  logic signed [DW-1:0] stage1_r;
  logic signed [DW-1:0] row0_r;
  logic signed [DW-1:0] row1_r;
  logic signed [DW-1:0] row2_r;
  logic                 read_r;
  logic                 win_r;
  logic                 busy_r;
  logic                 done_r;

  ifm_addr_gen #(.AW(AW), .LW(LW)) u_addr_gen (
    .clk  (clk),
    .rstn (rstn),
    .load (load_s),
    .adv  (adv_s),
    .base (bus.cfg_base),
    .w    (cfg_w_r),
    .h    (cfg_h_r),
    .addr (addr_s),
    .k    (k_s),
    .col  (col_s),
    .last (last_s)
  );

  assign k2_vld_s = rd_vld_r && (rd_k_r == 2'd2);

  // State register plus job-level status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_r == ST_DONE);
    end
  end

  // Next-state and read-issue decode; start outside IDLE is ignored.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    adv_s       = 1'b0;
    sram_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          load_s = 1'b1;
          if (dims_ok(bus.cfg_w, bus.cfg_h)) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!bus.stall) begin
          sram_en_s = 1'b1;
          adv_s     = 1'b1;
          if (last_s) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (k2_vld_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Job geometry is frozen at start so mid-job cfg changes have no effect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_w_r <= '0;
      cfg_h_r <= '0;
    end else if (load_s) begin
      cfg_w_r <= bus.cfg_w;
      cfg_h_r <= bus.cfg_h;
    end
  end

  // Read-return pipeline: the tag travels one cycle with the SRAM latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_r <= 1'b0;
      rd_k_r   <= 2'd0;
      rd_win_r <= 1'b0;
      stage0_r <= '0;
      stage1_r <= '0;
      row0_r   <= '0;
      row1_r   <= '0;
      row2_r   <= '0;
      read_r   <= 1'b0;
      win_r    <= 1'b0;
    end else begin
      rd_vld_r <= sram_en_s;
      rd_k_r   <= k_s;
      rd_win_r <= (col_s >= LW'(2));
      read_r   <= k2_vld_s;
      win_r    <= k2_vld_s && rd_win_r;
      if (rd_vld_r) begin
        case (rd_k_r)
          2'd0: stage0_r <= bus.sram_rdata;
          2'd1: stage1_r <= bus.sram_rdata;
          2'd2: begin
            row0_r <= stage0_r;
            row1_r <= stage1_r;
            row2_r <= bus.sram_rdata;
          end
          default: begin
            stage0_r <= stage0_r;
          end
        endcase
      end
    end
  end

  assign bus.sram_en   = sram_en_s;
  assign bus.sram_addr = addr_s;
  assign bus.ifm_row0  = row0_r;
  assign bus.ifm_row1  = row1_r;
  assign bus.ifm_row2  = row2_r;
  assign bus.ifm_read  = read_r;
  assign bus.win_valid = win_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule
